// File: rtl/bt_tx_scheduler.sv
// bt_tx_scheduler
//   Shares one UART transmitter between two byte-stream FIFOs. ch0 carries sensor
//   data and is only eligible with the link up and outside AT mode. ch1 carries
//   host/AT traffic and is eligible whenever it is non-empty. Channels are served
//   round-robin. Each grant is locked for a burst of up to MAX_BURST bytes. Every
//   byte is popped, latched, handed to the transmitter, and held until tx_done.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   at_mode, bt_state     AT-command mode, link-up indication
//   ch0_empty/rd_en/data  sensor FIFO interface (data valid the cycle after rd_en)
//   ch1_empty/rd_en/data  host FIFO interface (data valid the cycle after rd_en)
//   tx_start, tx_data     request and byte to the UART transmitter
//   tx_done               transmitter completion pulse
//   grant                 one-hot current owner (bit0 = ch0, bit1 = ch1), 00 when idle
//   busy                  high whenever the FSM is not idle
//   bytes_sent            bytes completed since reset (wraps)
module bt_tx_scheduler #(
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             at_mode,
  input  logic             bt_state,
  input  logic             ch0_empty,
  output logic             ch0_rd_en,
  input  logic [7:0]       ch0_data,
  input  logic             ch1_empty,
  output logic             ch1_rd_en,
  input  logic [7:0]       ch1_data,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_sent
);

  localparam logic [7:0] BurstMax = 8'(MAX_BURST);
  // GAP_CYCLES = 0 still spends one cycle in the gap state.
  localparam logic [3:0] GapLast  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLatch,
    StSend,
    StGap
  } state_e;

  state_e     state;
  logic [7:0] burst_cnt;
  logic [3:0] gap_cnt;
  logic       last_ch1;  // 1 when ch1 was the most recently served channel

  logic elig0;
  logic elig1;
  logic pick_ch1;
  logic cur_elig;

  assign elig0 = ~ch0_empty & bt_state & ~at_mode;
  assign elig1 = ~ch1_empty;

  // On a tie the channel not served last wins.
  assign pick_ch1 = elig1 & (~elig0 | ~last_ch1);

  // Eligibility of the channel that currently holds the grant.
  assign cur_elig = grant[1] ? elig1 : elig0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      grant      <= 2'b00;
      busy       <= 1'b0;
      ch0_rd_en  <= 1'b0;
      ch1_rd_en  <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      bytes_sent <= '0;
      burst_cnt  <= 8'd0;
      gap_cnt    <= 4'd0;
      last_ch1   <= 1'b1;
    end else begin
      // Read strobes are single-cycle; they are raised only on entry to POP.
      ch0_rd_en <= 1'b0;
      ch1_rd_en <= 1'b0;

      unique case (state)
        StIdle: begin
          if (elig0 | elig1) begin
            grant     <= pick_ch1 ? 2'b10 : 2'b01;
            ch0_rd_en <= ~pick_ch1;
            ch1_rd_en <= pick_ch1;
            burst_cnt <= 8'd0;
            busy      <= 1'b1;
            state     <= StPop;
          end
        end

        StPop: begin
          state <= StLatch;
        end

        StLatch: begin
          tx_data  <= grant[1] ? ch1_data : ch0_data;
          tx_start <= 1'b1;
          state    <= StSend;
        end

        StSend: begin
          if (tx_done) begin
            tx_start   <= 1'b0;
            bytes_sent <= bytes_sent + CNT_W'(1);
            burst_cnt  <= burst_cnt + 8'd1;
            gap_cnt    <= 4'd0;
            state      <= StGap;
          end
        end

        StGap: begin
          if (gap_cnt == GapLast) begin
            if ((burst_cnt < BurstMax) && cur_elig) begin
              // Continue the burst on the same grant.
              ch0_rd_en <= grant[0];
              ch1_rd_en <= grant[1];
              state     <= StPop;
            end else begin
              last_ch1 <= grant[1];
              grant    <= 2'b00;
              busy     <= 1'b0;
              state    <= StIdle;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
